instr_fetch_queue: RTL and testbench

//  Instruction-fetch front end for the 16-bit core. Consumes the PC address, issues pipelined

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/instr_fetch_queue.sv | 102 ++++++++++
 tb/tb_instr_fetch_queue.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared widths and helpers for the instruction-fetch front end.
package ifetch_pkg;

    localparam int IF_ADDR_W  = 16;
    localparam int IF_DATA_W  = 16;
    localparam int IF_INSTR_W = IF_DATA_W;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered FIFO with show-ahead read, synchronous active-low reset and a
// synchronous clear.
module sync_fifo
    import ifetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rp];

    // A write into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_wr = i_push & (~o_full | i_pop);
    assign w_rd = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= i_wdata;
                r_wp        <= (r_wp == LAST) ? '0 : r_wp + PW'(1);
            end
            if (w_rd) r_rp <= (r_rp == LAST) ? '0 : r_rp + PW'(1);
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: credit-based memory request issue, in-flight address
// tracking, drop of stale responses after a redirect, and decode queue.
module instr_fetch_queue
    import ifetch_pkg::*;
#(
    parameter int ADDR_W  = IF_ADDR_W,
    parameter int DATA_W  = IF_INSTR_W,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_pc_addr,
    output logic              o_pc_hold,
    input  logic              i_flush,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_dec_valid,
    output logic [DATA_W-1:0] o_dec_instr,
    output logic [ADDR_W-1:0] o_dec_pc,
    input  logic              i_dec_ready
);

    localparam int QCW = clog2(DEPTH + 1);
    localparam int ACW = clog2(MAX_OUT + 1);

    logic [ACW-1:0]           r_drop;
    logic [ACW-1:0]           w_out;
    logic [QCW-1:0]           w_q_count;
    logic                     w_a_full;
    logic                     w_a_empty;
    logic                     w_unused_q_full;
    logic                     w_q_empty;
    logic [ADDR_W-1:0]        w_rsp_addr;
    logic [ADDR_W+DATA_W-1:0] w_q_rdata;
    logic                     w_issue;
    logic                     w_discard;
    logic                     w_q_push;
    logic                     w_q_pop;

    // Each granted request reserves a queue slot, so responses never overflow.
    always_comb begin
        o_mem_req = i_rst_n && !i_flush && !w_a_full
                    && ((int'(w_q_count) + int'(w_out)) < DEPTH);
    end

    assign w_issue    = o_mem_req & i_mem_gnt;
    assign o_mem_addr = i_pc_addr;
    assign o_pc_hold  = !i_rst_n || (!i_flush && !w_issue);

    assign w_discard  = i_flush || (r_drop != '0);
    assign w_q_push   = i_mem_rvalid && !w_discard;
    assign o_dec_valid = i_rst_n && !w_q_empty;
    assign w_q_pop    = o_dec_valid && i_dec_ready;
    assign {o_dec_pc, o_dec_instr} = w_q_rdata;

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUT)) u_addr_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (1'b0),
        .i_push  (w_issue),
        .i_wdata (i_pc_addr),
        .i_pop   (i_mem_rvalid),
        .o_rdata (w_rsp_addr),
        .o_full  (w_a_full),
        .o_empty (w_a_empty),
        .o_count (w_out)
    );

    sync_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_instr_q (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_flush),
        .i_push  (w_q_push),
        .i_wdata ({w_rsp_addr, i_mem_rdata}),
        .i_pop   (w_q_pop),
        .o_rdata (w_q_rdata),
        .o_full  (w_unused_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    // On redirect every response still owed is stale, including ones already
    // marked by an earlier redirect, so the count is rebuilt from outstanding.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_drop <= '0;
        end else if (i_flush) begin
            r_drop <= w_out - ACW'(i_mem_rvalid);
        end else if (i_mem_rvalid && (r_drop != '0)) begin
            r_drop <= r_drop - ACW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_mem_rvalid) assert (!w_a_empty);
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed + random bench for instr_fetch_queue against a queue-level model.
module tb_instr_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_addr;
    logic        pc_hold;
    logic        flush;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        dec_valid;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic        dec_ready;

    instr_fetch_queue #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pc_addr    (pc_addr),
        .o_pc_hold    (pc_hold),
        .i_flush      (flush),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_dec_valid  (dec_valid),
        .o_dec_instr  (dec_instr),
        .o_dec_pc     (dec_pc),
        .i_dec_ready  (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] addr; logic kill; } infl_t;
    typedef struct packed { logic [15:0] pc; logic [15:0] instr; } dec_t;

    infl_t       infl[$];   // granted requests whose response is still owed
    dec_t        expq[$];   // instructions decode should see, in order
    logic [15:0] pop_log[$];
    logic [15:0] pc;
    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    int          grants = 0;
    int          holds  = 0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic gnt,
                        input bit rv_en, input logic rdy, input logic [15:0] tgt);
        logic  exp_req, exp_hold, rv;
        infl_t f;
        rst_n      = rst;
        flush      = fl;
        mem_gnt    = gnt;
        dec_ready  = rdy;
        pc_addr    = pc;
        rv         = rst && rv_en && (infl.size() > 0);
        mem_rvalid = rv;
        mem_rdata  = rv ? memf(infl[0].addr) : 16'h0;
        #1;
        exp_req  = rst && !fl && (infl.size() < MAX_OUT) && ((expq.size() + infl.size()) < DEPTH);
        exp_hold = !rst || (!fl && !(exp_req && gnt));
        chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
        chk("pc_hold", {31'd0, pc_hold}, {31'd0, exp_hold});
        if (pc_hold) holds++;
        if (exp_req) chk("mem_addr", {16'd0, mem_addr}, {16'd0, pc});
        if (rst && expq.size() > 0) begin
            chk("dec_valid", {31'd0, dec_valid}, 32'd1);
            chk("dec_pc", {16'd0, dec_pc}, {16'd0, expq[0].pc});
            chk("dec_instr", {16'd0, dec_instr}, {16'd0, expq[0].instr});
        end else begin
            chk("dec_valid", {31'd0, dec_valid}, 32'd0);
        end
        if (dec_valid && rdy) begin
            pops++;
            pop_log.push_back(dec_pc);
        end
        @(posedge clk);
        if (!rst) begin
            infl.delete();
            expq.delete();
            pc = 16'h0;
        end else begin
            if (expq.size() > 0 && rdy) void'(expq.pop_front());
            if (fl) expq.delete();
            if (rv) begin
                f = infl.pop_front();
                if (!f.kill && !fl) expq.push_back('{pc: f.addr, instr: memf(f.addr)});
            end
            if (fl) foreach (infl[i]) infl[i].kill = 1'b1;
            if (exp_req && gnt) begin
                infl.push_back('{addr: pc, kill: 1'b0});
                grants++;
                pc = pc + 16'd1;
            end
            if (fl) pc = tgt;
        end
        @(negedge clk);
    endtask

    initial begin
        int p0, g0, h0;
        rst_n = 1'b0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 16'h0; dec_ready = 1'b0; pc = 16'h0; pc_addr = 16'h0;
        @(posedge clk);
        @(negedge clk);

        // Reset held, then release with grant available.
        step(0, 0, 0, 0, 0, 16'h0);
        step(0, 0, 1, 0, 0, 16'h0);
        chk("rst_dec_pc", {16'd0, dec_pc}, 32'd0);
        chk("rst_dec_instr", {16'd0, dec_instr}, 32'd0);
        step(1, 0, 1, 0, 1, 16'h0);

        // Streaming: one instruction per cycle after the pipe fills.
        p0 = pops;
        repeat (12) step(1, 0, 1, 1, 1, 16'h0);
        chk("stream_pops", pops - p0, 11);
        chk("stream_first_pc", {16'd0, pop_log[p0]}, 32'd0);
        chk("stream_last_pc", {16'd0, pop_log[p0 + 10]}, 32'd10);

        // Backpressure until full, then a single pop frees exactly one request.
        repeat (6) step(1, 0, 1, 1, 0, 16'h0);
        g0 = grants;
        step(1, 0, 1, 1, 1, 16'h0);
        step(1, 0, 1, 1, 0, 16'h0);
        step(1, 0, 1, 1, 0, 16'h0);
        chk("bp_one_req", grants - g0, 1);
        repeat (6) step(1, 0, 0, 1, 1, 16'h0);

        // Redirect with two requests in flight and a response in the same cycle.
        step(1, 0, 1, 0, 1, 16'h0);
        step(1, 0, 1, 0, 1, 16'h0);
        step(1, 1, 1, 1, 1, 16'h0040);
        chk("flush_dec_valid", {31'd0, dec_valid}, 32'd0);
        p0 = pops;
        repeat (6) step(1, 0, 1, 1, 1, 16'h0);
        chk("flush_first_pc", {16'd0, pop_log[p0]}, 32'h0040);

        // Memory stall: no grants for five cycles.
        h0 = holds;
        g0 = grants;
        repeat (5) step(1, 0, 0, 0, 1, 16'h0);
        chk("stall_hold", holds - h0, 5);
        chk("stall_grants", grants - g0, 0);

        // Fill to DEPTH, then drain while refilling; PCs must stay consecutive.
        repeat (8) step(1, 0, 1, 1, 0, 16'h0);
        p0 = pops;
        repeat (12) step(1, 0, 1, 1, 1, 16'h0);
        for (int i = p0; i + 1 < pops; i++)
            chk("full_seq", {16'd0, pop_log[i + 1]}, {16'd0, pop_log[i] + 16'd1});

        // Random traffic with occasional redirects and resets.
        repeat (400) begin
            step(($urandom % 100) != 0, ($urandom % 12) == 0, ($urandom % 4) != 0,
                 ($urandom % 3) != 0, ($urandom % 3) != 0, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
